// File: rtl/settings_bus_sequencer_pkg.sv
// ============================================================================
// Module      : settings_seq_pkg
// Description : Shared state encoding and constants for the settings-bus
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package settings_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } seq_state_e;

  localparam int c_min_gap = 1;

endpackage

`default_nettype wire

// File: rtl/settings_bus_sequencer_fifo.sv
// ============================================================================
// Module      : settings_seq_fifo
// Description : Synchronous FIFO with wrap-bit pointers and registered fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settings_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int c_aw = $clog2(DEPTH),
  localparam int c_fw = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [c_fw-1:0]  fill
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_fw-1:0]  r_fill;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // Same index with differing wrap bits means the pointers are a lap apart.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                  (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push = push && !w_full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign fill   = r_fill;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
      end
      r_fill <= r_fill + c_fw'(w_push) - c_fw'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/settings_bus_sequencer.sv
// ============================================================================
// Module      : settings_bus_sequencer
// Description : Buffers settings writes and replays them as one-cycle strobes
//               with an idle gap onto NUM_CH buses. Define
//               SETTINGS_SEQ_CHK_EN to add channel range checking (ch_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settings_bus_sequencer
  import settings_seq_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int GAP    = 1,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int c_fw  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_ch,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_data,
  output logic [NUM_CH-1:0] set_stb,
  output logic [AWIDTH-1:0] set_addr,
  output logic [DWIDTH-1:0] set_data,
  output logic              busy,
  output logic [c_fw-1:0]   fill
`ifdef SETTINGS_SEQ_CHK_EN
  ,
  output logic              ch_err
`endif
);

  typedef struct packed {
    logic [CW-1:0]     ch;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } entry_t;

  localparam int c_gap_eff = (GAP < c_min_gap) ? c_min_gap : GAP;
  localparam int c_gw      = (c_gap_eff > 1) ? $clog2(c_gap_eff) : 1;
  localparam logic [c_gw-1:0] c_gap_load = c_gw'(c_gap_eff - 1);

  seq_state_e        r_state;
  logic [c_gw-1:0]   r_gap_cnt;
  logic [NUM_CH-1:0] r_stb;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic              r_busy;
  logic              r_ready;

  entry_t            w_in_entry;
  entry_t            w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_ch_bad;
  logic [c_fw-1:0]   w_fill;
  logic [c_fw-1:0]   w_fill_next;
  logic [NUM_CH-1:0] w_stb_one;

  assign w_in_entry = '{ch: in_ch, addr: in_addr, data: in_data};

  settings_seq_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (w_in_entry),
    .pop     (w_pop),
    .rdata   (w_head),
    .empty   (w_empty),
    .fill    (w_fill)
  );

  // The last GAP cycle pops directly so back-to-back strobes stay GAP+1 apart.
  assign w_push      = in_valid && r_ready;
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_gap_cnt == '0)));
  assign w_fill_next = w_fill + c_fw'(w_push) - c_fw'(w_pop);
  assign w_stb_one   = NUM_CH'(1) << w_head.ch;

`ifdef SETTINGS_SEQ_CHK_EN
  logic r_ch_err;

  assign w_ch_bad = ({1'b0, w_head.ch} >= (CW + 1)'(NUM_CH));
  assign ch_err   = r_ch_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_err <= 1'b0;
    end else if (w_pop && w_ch_bad) begin
      r_ch_err <= 1'b1;
    end
  end
`else
  assign w_ch_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_stb     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= (w_fill_next != c_fw'(DEPTH));
      r_busy  <= 1'b1;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - c_gw'(1);
          end else if (w_pop) begin
            r_stb   <= w_ch_bad ? '0 : w_stb_one;
            r_addr  <= w_ch_bad ? '0 : w_head.addr;
            r_data  <= w_ch_bad ? '0 : w_head.data;
            r_state <= ST_STROBE;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= (w_fill_next != '0);
          end
        end
        ST_STROBE: begin
          r_stb     <= '0;
          r_addr    <= '0;
          r_data    <= '0;
          r_gap_cnt <= c_gap_load;
          r_state   <= ST_GAP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign set_stb  = r_stb;
  assign set_addr = r_addr;
  assign set_data = r_data;
  assign busy     = r_busy;
  assign in_ready = r_ready;
  assign fill     = w_fill;

endmodule

`default_nettype wire
